// File: rtl/s10_dot_accum.sv
// Parametrised DOT-lane dot product feeding a framed streaming accumulator.
// Three register stages: lane products, exact lane sum, then accumulate with optional saturation.
module s10_dot_accum #(
  parameter int unsigned SIZEA  = 8,
  parameter int unsigned SIZEB  = 8,
  parameter int unsigned DOT    = 5,
  parameter int unsigned SIGNED = 1,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned SAT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [SIZEA-1:0] din_a [0:DOT-1],
  input  logic [SIZEB-1:0] din_b [0:DOT-1],
  output logic             out_valid,
  output logic [ACC_W-1:0] dout,
  output logic             ovf
);

  localparam int unsigned PROD_W = SIZEA + SIZEB;
  localparam int unsigned SUM_W  = PROD_W + $clog2(DOT);
  localparam int unsigned EXT_W  = ACC_W + 1;

  logic [PROD_W-1:0] w_ea   [0:DOT-1];
  logic [PROD_W-1:0] w_eb   [0:DOT-1];
  logic [PROD_W-1:0] w_prod [0:DOT-1];
  logic [PROD_W-1:0] r_prod [0:DOT-1];
  logic              r_s1_valid, r_s1_first, r_s1_last;

  logic [SUM_W-1:0]  w_sum;
  logic [SUM_W-1:0]  r_sum;
  logic              r_s2_valid, r_s2_first, r_s2_last;

  logic [ACC_W-1:0]  r_acc;
  logic              r_sticky;
  logic              r_open;

  logic [EXT_W-1:0]  w_sum_ext, w_base, w_full;
  logic [ACC_W-1:0]  w_clamp, w_acc_next;
  logic              w_start, w_ovf_cur, w_ovf_vec;

  // Operands widened to the full product width so a truncated multiply is exact.
  always_comb begin
    for (int i = 0; i < int'(DOT); i++) begin
      if (SIGNED != 0) begin
        w_ea[i] = PROD_W'($signed(din_a[i]));
        w_eb[i] = PROD_W'($signed(din_b[i]));
      end else begin
        w_ea[i] = PROD_W'(din_a[i]);
        w_eb[i] = PROD_W'(din_b[i]);
      end
      w_prod[i] = w_ea[i] * w_eb[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      r_s1_first <= in_valid & in_first;
      r_s1_last  <= in_valid & in_last;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DOT); i++) begin
      r_prod[i] <= w_prod[i];
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < int'(DOT); i++) begin
      if (SIGNED != 0) w_sum = w_sum + SUM_W'($signed(r_prod[i]));
      else             w_sum = w_sum + SUM_W'(r_prod[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
    end
    r_sum <= w_sum;
  end

  // A beat with no open vector behind it starts a fresh one, first flag or not.
  always_comb begin
    w_sum_ext  = '0;
    w_base     = '0;
    w_full     = '0;
    w_clamp    = '0;
    w_acc_next = '0;
    w_ovf_cur  = 1'b0;
    w_ovf_vec  = 1'b0;
    w_start    = r_s2_first | ~r_open;
    if (SIGNED != 0) begin
      w_sum_ext = EXT_W'($signed(r_sum));
      w_base    = EXT_W'($signed(r_acc));
    end else begin
      w_sum_ext = EXT_W'(r_sum);
      w_base    = EXT_W'(r_acc);
    end
    if (w_start) w_base = '0;
    w_full = w_base + w_sum_ext;
    if (SIGNED != 0) begin
      w_ovf_cur = w_full[ACC_W] ^ w_full[ACC_W-1];
      w_clamp   = w_full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      w_ovf_cur = w_full[ACC_W];
      w_clamp   = '1;
    end
    w_acc_next = ((SAT != 0) && w_ovf_cur) ? w_clamp : w_full[ACC_W-1:0];
    w_ovf_vec  = (w_start ? 1'b0 : r_sticky) | w_ovf_cur;
  end

  // dout/ovf only change on a last beat so they hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_sticky  <= 1'b0;
      r_open    <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (r_s2_valid) begin
        r_acc    <= w_acc_next;
        r_sticky <= w_ovf_vec;
        r_open   <= ~r_s2_last;
        if (r_s2_last) begin
          out_valid <= 1'b1;
          dout      <= w_acc_next;
          ovf       <= w_ovf_vec;
        end
      end
    end
  end

endmodule
